// File: rtl/debugger_pkg.sv
// Shared definitions for the debug-frame serializer: FSM state encoding and default header byte.
package debugger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOF     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;

endpackage

// File: rtl/debugger_frame_tx.sv
// Debug-frame serializer: SOF header, payload MSB byte first, optional XOR checksum, one byte per UART write.
// Define DEBUGGER_TX_CHECKSUM_EN to append the checksum byte after the payload.
import debugger_pkg::*;

module debugger_frame_tx #(
  parameter int unsigned FRAME_BYTES = 220,
  parameter logic [7:0]  SOF_BYTE    = DEFAULT_SOF_BYTE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     send_start,
  input  logic [FRAME_BYTES*8-1:0] send_data,
  input  logic                     tx_busy,
  output logic                     wr_uart,
  output logic [7:0]               w_data,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned    CW       = $clog2(FRAME_BYTES + 1);
  localparam logic [CW-1:0]  LAST_IDX = CW'(FRAME_BYTES - 1);

  state_t                   state_q, state_d;
  state_t                   ret_q, ret_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [FRAME_BYTES*8-1:0] shadow_q, shadow_d;
  logic                     wr_q, wr_d;
  logic [7:0]               wdata_q, wdata_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [7:0]               cur_byte;
`ifdef DEBUGGER_TX_CHECKSUM_EN
  logic [7:0]               chk_q, chk_d;
`endif

  assign cur_byte = shadow_q[(FRAME_BYTES - 1 - 32'(cnt_q)) * 8 +: 8];

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    wr_d     = 1'b0;
    done_d   = 1'b0;
`ifdef DEBUGGER_TX_CHECKSUM_EN
    chk_d    = chk_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (send_start) begin
          shadow_d = send_data;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_SOF;
`ifdef DEBUGGER_TX_CHECKSUM_EN
          chk_d    = '0;
`endif
        end
      end
      ST_SOF: begin
        if (!tx_busy) begin
          wr_d    = 1'b1;
          wdata_d = SOF_BYTE;
          ret_d   = ST_PAYLOAD;
          state_d = ST_GAP;
        end
      end
      ST_PAYLOAD: begin
        if (!tx_busy) begin
          wr_d    = 1'b1;
          wdata_d = cur_byte;
          state_d = ST_GAP;
`ifdef DEBUGGER_TX_CHECKSUM_EN
          chk_d   = chk_q ^ cur_byte;
`endif
          if (cnt_q == LAST_IDX) begin
`ifdef DEBUGGER_TX_CHECKSUM_EN
            ret_d = ST_CHK;
`else
            ret_d = ST_DONE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
            ret_d = ST_PAYLOAD;
          end
        end
      end
`ifdef DEBUGGER_TX_CHECKSUM_EN
      ST_CHK: begin
        if (!tx_busy) begin
          wr_d    = 1'b1;
          wdata_d = chk_q;
          ret_d   = ST_DONE;
          state_d = ST_GAP;
        end
      end
`endif
      // frame_done is registered here so it is high exactly during the DONE cycle
      ST_GAP: begin
        state_d = ret_q;
        done_d  = (ret_q == ST_DONE);
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ret_q    <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DEBUGGER_TX_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef DEBUGGER_TX_CHECKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

  assign wr_uart    = wr_q;
  assign w_data     = wdata_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_debugger_frame_tx.sv
// Directed bench for debugger_frame_tx with FRAME_BYTES=4 and a 10-cycle UART busy model.
module tb_debugger_frame_tx;

  localparam int unsigned FB = 4;
`ifdef DEBUGGER_TX_CHECKSUM_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        send_start;
  logic [31:0] send_data;
  logic        tx_busy;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        busy;
  logic        frame_done;
  logic        force_busy;
  int unsigned uart_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  log_q[$];
  int          done_cnt = 0;
  bit          overlap = 1'b0;
  logic [7:0]  exp_b[6] = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};

  debugger_frame_tx #(.FRAME_BYTES(FB), .SOF_BYTE(8'hA5)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .send_start(send_start),
    .send_data (send_data),
    .tx_busy   (tx_busy),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // UART model: busy for 10 cycles starting the cycle after each write
  assign tx_busy = force_busy | (uart_cnt != 0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             uart_cnt <= 0;
    else if (wr_uart)       uart_cnt <= 10;
    else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
  end

  always @(negedge clk) begin
    if (wr_uart) begin
      log_q.push_back(w_data);
      if (frame_done) overlap = 1'b1;
    end
    if (frame_done) done_cnt++;
  end

  task automatic start_frame(input logic [31:0] d);
    @(negedge clk);
    send_start = 1'b1;
    send_data  = d;
    @(negedge clk);
    send_start = 1'b0;
    #1;
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (done_cnt > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; force_busy = 1'b0; send_start = 1'b0; send_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (wr_uart !== 1'b0)    begin errors++; $display("FAIL reset_wr got %b want 0", wr_uart); end
    checks++; if (w_data !== 8'h00)    begin errors++; $display("FAIL reset_wdata got %h want 00", w_data); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int base; bit ok;
    log_q.delete(); base = done_cnt;
    start_frame(32'hDEADBEEF);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b want 1", busy); end
    wait_done(base, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got 0 want 1"); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_at_done got %b want 1", busy); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got %b want 0", busy); end
    checks++; if (log_q.size() != NW) begin errors++; $display("FAIL basic_count got %0d want %0d", log_q.size(), NW); end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (log_q[i] !== exp_b[i]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", i, log_q[i], exp_b[i]); end
    end
    checks++; if (overlap) begin errors++; $display("FAIL done_wr_overlap got 1 want 0"); end
  endtask

  task automatic test_data_change;
    int base; bit ok;
    log_q.delete(); base = done_cnt;
    start_frame(32'hDEADBEEF);
    send_data = 32'h12345678;
    wait_done(base, ok);
    checks++; if (!ok) begin errors++; $display("FAIL chg_timeout got 0 want 1"); end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (log_q[i] !== exp_b[i]) begin errors++; $display("FAIL chg_byte%0d got %h want %h", i, log_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_hold;
    int base, n0; bit ok;
    log_q.delete(); base = done_cnt;
    start_frame(32'hDEADBEEF);
    for (int i = 0; i < 200 && log_q.size() < 2; i++) begin @(negedge clk); #1; end
    force_busy = 1'b1;
    n0 = log_q.size();
    checks++; if (n0 != 2) begin errors++; $display("FAIL hold_pre_count got %0d want 2", n0); end
    repeat (100) @(negedge clk);
    #1;
    checks++; if (log_q.size() != n0) begin errors++; $display("FAIL hold_writes got %0d want %0d", log_q.size(), n0); end
    force_busy = 1'b0;
    wait_done(base, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_timeout got 0 want 1"); end
    checks++; if (log_q.size() != NW) begin errors++; $display("FAIL hold_count got %0d want %0d", log_q.size(), NW); end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (log_q[i] !== exp_b[i]) begin errors++; $display("FAIL hold_byte%0d got %h want %h", i, log_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_ignore_start;
    int base; bit ok;
    log_q.delete(); base = done_cnt;
    start_frame(32'hDEADBEEF);
    for (int i = 0; i < 200 && log_q.size() < 1; i++) begin @(negedge clk); #1; end
    @(negedge clk); send_start = 1'b1; send_data = 32'h12345678;
    @(negedge clk); send_start = 1'b0;
    wait_done(base, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_timeout got 0 want 1"); end
    repeat (40) @(negedge clk);
    #1;
    checks++; if (done_cnt != base + 1) begin errors++; $display("FAIL ign_done_count got %0d want %0d", done_cnt - base, 1); end
    checks++; if (log_q.size() != NW) begin errors++; $display("FAIL ign_count got %0d want %0d", log_q.size(), NW); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy got %b want 0", busy); end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (log_q[i] !== exp_b[i]) begin errors++; $display("FAIL ign_byte%0d got %h want %h", i, log_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int base, n; bit ok;
    log_q.delete(); base = done_cnt; n = 0;
    start_frame(32'hDEADBEEF);
    for (int i = 0; i < 200 && n < 2; i++) begin
      @(negedge clk);
      if (wr_uart) n++;
    end
    checks++; if (n != 2) begin errors++; $display("FAIL rst_mid_reach got %0d want 2", n); end
    rst_n = 1'b0;
    #1;
    checks++; if (wr_uart !== 1'b0)    begin errors++; $display("FAIL rst_mid_wr got %b want 0", wr_uart); end
    checks++; if (w_data !== 8'h00)    begin errors++; $display("FAIL rst_mid_wdata got %h want 00", w_data); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    checks++; if (done_cnt != base) begin errors++; $display("FAIL rst_mid_no_done got %0d want 0", done_cnt - base); end
    log_q.delete();
    start_frame(32'hDEADBEEF);
    wait_done(base, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_timeout got 0 want 1"); end
    checks++; if (log_q.size() != NW) begin errors++; $display("FAIL rst_mid_count got %0d want %0d", log_q.size(), NW); end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (log_q[i] !== exp_b[i]) begin errors++; $display("FAIL rst_mid_byte%0d got %h want %h", i, log_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int base; bit ok, seen;
    log_q.delete(); base = done_cnt;
    @(negedge clk); send_start = 1'b1; send_data = 32'hDEADBEEF;
    wait_done(base, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout got 0 want 1"); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !busy; i++) begin @(negedge clk); #1; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (!busy) seen = 1'b1;
      if (seen && busy) break;
    end
    send_start = 1'b0;
    checks++; if (!(seen && busy)) begin errors++; $display("FAIL b2b_restart got %b want 1", busy); end
    wait_done(base + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout got 0 want 1"); end
    repeat (20) @(negedge clk);
    #1;
    checks++; if (done_cnt != base + 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - base); end
    checks++; if (log_q.size() != 2 * NW) begin errors++; $display("FAIL b2b_count got %0d want %0d", log_q.size(), 2 * NW); end
    for (int i = 0; i < 2 * NW; i++) begin
      checks++;
      if (log_q[i] !== exp_b[i % NW]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, log_q[i], exp_b[i % NW]); end
    end
    checks++; if (overlap) begin errors++; $display("FAIL b2b_overlap got 1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_data_change();
    test_hold();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
